// File: rtl/dmem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter slice.
//   arb_state_t   : arbiter FSM states (free arbitration, or locked to a port)
//   P_CORE/P_LOAD : port indices for the core load/store port and the loader
//   DEFAULT_DEPTH : default number of valid word locations in the data memory
//   otherPort()   : returns the index of the opposite port of a 2-port pair
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_t;

   localparam int P_CORE        = 0;
   localparam int P_LOAD        = 1;
   localparam int DEFAULT_DEPTH = 256;

   // With only two requesters the "other" port is simply the inverted index.
   function automatic logic otherPort(input logic port);
      return ~port;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
// Requester-side bus of the data-memory arbiter: both ports' commands and the
// shared grant/response signals.
//   req[1:0], lock[1:0], wr[1:0] : per-port request, burst-lock hint, write
//   addr0/addr1, wdata0/wdata1   : per-port word address and write data
//   gnt[1:0]                     : combinational one-hot grant
//   rvalid[1:0], rdata, err      : registered response, one cycle after grant
// Modports:
//   master : the requesters (core port and loader), drive commands
//   slave  : the arbiter, drives grant and response
// ----------------------------------------------------------------------------
interface dmem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);

   logic [1:0]    req;
   logic [1:0]    lock;
   logic [1:0]    wr;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic [1:0]    gnt;
   logic [1:0]    rvalid;
   logic [DW-1:0] rdata;
   logic          err;

   modport master (
      output req, lock, wr, addr0, addr1, wdata0, wdata1,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, lock, wr, addr0, addr1, wdata0, wdata1,
      output gnt, rvalid, rdata, err
   );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2
// Combinational 2-way round-robin pick.
//   req_i[1:0] : per-port request
//   rrPtr_i    : port that wins when both request
//   gnt_o[1:0] : one-hot pick, zero when nobody requests
// ----------------------------------------------------------------------------
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       rrPtr_i,
   output logic [1:0] gnt_o
);

   // A lone requester always wins; on contention the round-robin pointer
   // decides, so neither port can starve the other in free arbitration.
   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o[P_CORE] = 1'b1;
         2'b10:   gnt_o[P_LOAD] = 1'b1;
         2'b11: begin
            if (rrPtr_i) begin
               gnt_o[P_LOAD] = 1'b1;
            end else begin
               gnt_o[P_CORE] = 1'b1;
            end
         end
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-cycle core's data memory between the core load/store port
// (port 0) and the loader port (port 1). Free arbitration is round-robin; a
// granted port holding lock keeps the memory for a burst that is cut off after
// MAX_BURST grants if the other port is waiting.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : requester bus (slave side), commands in, grant/response out
//   mem_A      : memory word address, from the granted port (port 0 if idle)
//   mem_WD     : memory write data, from the granted port
//   mem_we     : memory write enable, only for granted in-range writes
//   mem_RD     : combinational memory read data
// Parameters: AW/DW address/data width, DEPTH valid words, MAX_BURST limit.
// ----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus,
   output logic [AW-1:0] mem_A,
   output logic [DW-1:0] mem_WD,
   output logic          mem_we,
   input  logic [DW-1:0] mem_RD
);

   localparam int            BW        = $clog2(MAX_BURST + 1);
   localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

   arb_state_t    state_q, state_d;
   logic          rrPtr_q, rrPtr_d;
   logic [BW-1:0] burstCnt_q, burstCnt_d;
   logic [BW-1:0] burstInc;
   logic [1:0]    pick;
   logic [1:0]    gnt;
   logic          lockPort;
   logic          gntIdx;
   logic [AW-1:0] selAddr;
   logic [DW-1:0] selData;
   logic          selWr;
   logic          inRange;
   logic [1:0]    rvalid_q;
   logic [DW-1:0] rdata_q;
   logic          err_q;

   rr_pick2 uPick (
      .req_i   (bus.req),
      .rrPtr_i (rrPtr_q),
      .gnt_o   (pick)
   );

   // Burst length including the grant being made this cycle. It saturates so
   // an uncontended burst can run forever without the counter wrapping.
   always_comb begin
      burstInc = burstCnt_q;
      if (burstCnt_q != BURST_MAX) begin
         burstInc = burstCnt_q + BW'(1);
      end
   end

   // The locked states only differ in which port owns the memory.
   always_comb begin
      lockPort = (state_q == LOCK1);
   end

   // Next-state and grant logic. In ARB the round-robin pick is granted and
   // the pointer moves past the winner; a locked winner starts a burst.
   // In a locked state only the owner is served. The burst ends when the owner
   // stops requesting, stops locking, or has used up MAX_BURST grants while
   // the other port is waiting; in the last case the waiting port gets
   // priority in the very next cycle so there is no idle bubble.
   // Reset suppresses all grants so nothing is written in a reset cycle.
   always_comb begin
      state_d    = state_q;
      rrPtr_d    = rrPtr_q;
      burstCnt_d = burstCnt_q;
      gnt        = 2'b00;
      if (!rst) begin
         case (state_q)
            ARB: begin
               gnt = pick;
               if (|pick) begin
                  rrPtr_d = otherPort(pick[P_LOAD]);
                  if (bus.lock[pick[P_LOAD]]) begin
                     state_d    = pick[P_LOAD] ? LOCK1 : LOCK0;
                     burstCnt_d = BW'(1);
                  end
               end
            end
            LOCK0, LOCK1: begin
               if (!bus.req[lockPort]) begin
                  state_d    = ARB;
                  burstCnt_d = '0;
               end else begin
                  gnt[lockPort] = 1'b1;
                  burstCnt_d    = burstInc;
                  if (!bus.lock[lockPort]) begin
                     state_d    = ARB;
                     burstCnt_d = '0;
                  end else if ((burstInc == BURST_MAX) && bus.req[otherPort(lockPort)]) begin
                     state_d    = ARB;
                     rrPtr_d    = otherPort(lockPort);
                     burstCnt_d = '0;
                  end
               end
            end
            default: begin
               state_d    = ARB;
               burstCnt_d = '0;
            end
         endcase
      end
   end

   // Arbitration state register; reset drops any lock immediately and makes
   // port 0 the winner of the next contention.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB;
         rrPtr_q    <= 1'b0;
         burstCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rrPtr_q    <= rrPtr_d;
         burstCnt_q <= burstCnt_d;
      end
   end

   // Memory pin mux. With no grant the core port's command is presented so
   // the address bus has a defined, stable source. The range check compares
   // the full address unsigned, so huge addresses never alias into memory.
   always_comb begin
      gntIdx  = gnt[P_LOAD];
      selAddr = gntIdx ? bus.addr1  : bus.addr0;
      selData = gntIdx ? bus.wdata1 : bus.wdata0;
      selWr   = bus.wr[gntIdx];
      inRange = ({1'b0, selAddr} < DEPTH_EXT);
      mem_we  = (|gnt) & selWr & inRange;
   end

   assign mem_A   = selAddr;
   assign mem_WD  = selData;
   assign bus.gnt = gnt;

   // Response registers. Read data is captured at the grant edge for writes
   // too, which gives the pre-write contents; out-of-range accesses return
   // zero with err set. rdata/err hold between grants.
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 2'b00;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= gnt;
         if (|gnt) begin
            rdata_q <= inRange ? mem_RD : '0;
            err_q   <= ~inRange;
         end
      end
   end

   assign bus.rvalid = rvalid_q;
   assign bus.rdata  = rdata_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter: a behavioural memory sits on the
// memory pins, and a reference model of the arbitration rules and memory
// contents predicts grants, write enables and responses every cycle.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int DEPTH = 256;
   localparam int MAXB  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] memA;
   logic [31:0] memWD;
   logic [31:0] memRD;
   logic        memWe;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.AW(32), .DW(32)) bif ();

   dmem_arbiter #(
      .AW(32), .DW(32), .DEPTH(DEPTH), .MAX_BURST(MAXB)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bif.slave),
      .mem_A  (memA),
      .mem_WD (memWD),
      .mem_we (memWe),
      .mem_RD (memRD)
   );

   // Behavioural data memory. It can be preloaded through the fill port while
   // the arbiter is held in reset; out-of-range reads return a non-zero
   // pattern so the arbiter's zeroing of such reads is visible.
   logic [31:0] tbMem [DEPTH];
   logic        fillEn;
   logic [7:0]  fillAddr;
   logic [31:0] fillData;

   always @(posedge clk) begin
      if (fillEn) begin
         tbMem[fillAddr] <= fillData;
      end else if (memWe) begin
         tbMem[memA[7:0]] <= memWD;
      end
   end

   assign memRD = (memA < 32'(DEPTH)) ? tbMem[memA[7:0]] : 32'hA5A5A5A5;

   int checks = 0;
   int errors = 0;

   // Reference model: which port (if any) currently owns a burst, how many
   // grants the burst has had, which port is preferred on contention, the
   // expected memory contents and the response expected after the next edge.
   int          owner;
   int          burstLen;
   int          rrPref;
   logic [31:0] refMem [DEPTH];
   logic [1:0]  expRvalid;
   logic [31:0] expRdata;
   logic        expErr;
   logic [1:0]  lastGnt;
   logic        lastWe;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs (called at a falling edge), check the
   // combinational outputs, advance the model, then check the registered
   // response at the next falling edge.
   task automatic applyStimulus(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                                input logic [1:0] w, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1);
      int          g;
      logic [1:0]  expG;
      logic [31:0] a;
      logic [31:0] d;
      logic        inR;
      logic        expWe;
      rst        = r;
      bif.req    = rq;
      bif.lock   = lk;
      bif.wr     = w;
      bif.addr0  = a0;
      bif.addr1  = a1;
      bif.wdata0 = d0;
      bif.wdata1 = d1;
      #1;
      g = -1;
      if (!r) begin
         if (owner >= 0) begin
            if (rq[owner]) g = owner;
         end else if (rq == 2'b11) begin
            g = rrPref;
         end else if (rq[0]) begin
            g = 0;
         end else if (rq[1]) begin
            g = 1;
         end
      end
      expG  = (g < 0) ? 2'b00 : (2'b01 << g);
      a     = (g == 1) ? a1 : a0;
      d     = (g == 1) ? d1 : d0;
      inR   = (a < 32'(DEPTH));
      expWe = (g >= 0) ? (w[g] && inR) : 1'b0;
      checkOutput("gnt", bif.gnt, expG);
      checkOutput("mem_we", memWe, expWe);
      if (g >= 0) begin
         checkOutput("mem_A", memA, a);
         if (w[g]) checkOutput("mem_WD", memWD, d);
      end
      lastGnt = bif.gnt;
      lastWe  = memWe;
      if (r) begin
         owner     = -1;
         burstLen  = 0;
         rrPref    = 0;
         expRvalid = 2'b00;
         expRdata  = '0;
         expErr    = 1'b0;
      end else begin
         expRvalid = expG;
         if (g >= 0) begin
            expRdata = inR ? refMem[a[7:0]] : 32'h0;
            expErr   = !inR;
            if (inR && w[g]) refMem[a[7:0]] = d;
         end
         if (owner < 0) begin
            if (g >= 0) begin
               rrPref = 1 - g;
               if (lk[g]) begin
                  owner    = g;
                  burstLen = 1;
               end
            end
         end else if (!rq[owner]) begin
            owner = -1;
         end else begin
            if (burstLen < MAXB) burstLen++;
            if (!lk[owner]) begin
               owner = -1;
            end else if (burstLen == MAXB && rq[1-owner]) begin
               rrPref = 1 - owner;
               owner  = -1;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      checkOutput("rvalid", bif.rvalid, expRvalid);
      checkOutput("rdata", bif.rdata, expRdata);
      checkOutput("err", bif.err, expErr);
   endtask

   logic        pv [2];
   logic [1:0]  pw;
   logic [31:0] pa [2];
   logic [31:0] pd [2];
   logic [1:0]  lk;
   logic        rr;
   int          burstSeen;
   logic [1:0]  afterBurst;

   // Preload memory under reset, then run the directed scenarios followed by
   // a randomized mix of contending, locking, dropping and reset cycles.
   initial begin
      owner      = -1;
      burstLen   = 0;
      rrPref     = 0;
      rst        = 1'b1;
      fillEn     = 1'b1;
      fillAddr   = '0;
      fillData   = '0;
      bif.req    = '0;
      bif.lock   = '0;
      bif.wr     = '0;
      bif.addr0  = '0;
      bif.addr1  = '0;
      bif.wdata0 = '0;
      bif.wdata1 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fillAddr  = 8'(i);
         fillData  = $urandom;
         refMem[i] = fillData;
         @(posedge clk);
         #1;
      end
      fillEn = 1'b0;
      @(negedge clk);

      applyStimulus(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      applyStimulus(1, 2'b11, 2'b11, 2'b11, 1, 2, 3, 4);

      applyStimulus(0, 2'b01, 2'b00, 2'b01, 5, 0, 32'hDEADBEEF, 0);
      checkOutput("tp1WriteWe", lastWe, 1'b1);
      applyStimulus(0, 2'b01, 2'b00, 2'b00, 5, 0, 0, 0);
      checkOutput("tp1ReadWe", lastWe, 1'b0);
      checkOutput("tp1Rvalid", bif.rvalid, 2'b01);
      checkOutput("tp1Rdata", bif.rdata, 32'hDEADBEEF);
      checkOutput("tp1Err", bif.err, 1'b0);

      applyStimulus(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 2'b11, 2'b00, 2'b00, 3, 4, 0, 0);
         checkOutput("tp2Alternate", lastGnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      end

      applyStimulus(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      applyStimulus(0, 2'b10, 2'b10, 2'b00, 0, 9, 0, 0);
      burstSeen  = (lastGnt == 2'b10) ? 1 : 0;
      afterBurst = 2'b00;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 2'b11, 2'b10, 2'b00, 1, 9, 0, 0);
         if (afterBurst == 2'b00) begin
            if (lastGnt == 2'b10) burstSeen++;
            else afterBurst = lastGnt;
         end
      end
      checkOutput("tp3BurstLen", burstSeen, MAXB);
      checkOutput("tp3NextGnt", afterBurst, 2'b01);

      applyStimulus(0, 2'b01, 2'b00, 2'b01, 256, 0, 32'h12345678, 0);
      checkOutput("tp4WriteWe", lastWe, 1'b0);
      checkOutput("tp4WriteErr", bif.err, 1'b1);
      applyStimulus(0, 2'b01, 2'b00, 2'b00, 32'hFFFFFFFF, 0, 0, 0);
      checkOutput("tp4ReadWe", lastWe, 1'b0);
      checkOutput("tp4ReadErr", bif.err, 1'b1);
      checkOutput("tp4ReadRdata", bif.rdata, 32'h0);

      applyStimulus(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
      applyStimulus(0, 2'b10, 2'b10, 2'b10, 0, 7, 0, 32'hCAFE0001);
      applyStimulus(1, 2'b10, 2'b10, 2'b10, 0, 8, 0, 32'hCAFE0002);
      checkOutput("tp5RstWe", lastWe, 1'b0);
      checkOutput("tp5RstGnt", lastGnt, 2'b00);
      checkOutput("tp5RstRvalid", bif.rvalid, 2'b00);
      applyStimulus(0, 2'b11, 2'b00, 2'b00, 8, 7, 0, 0);
      checkOutput("tp5FirstWinner", lastGnt, 2'b01);
      applyStimulus(0, 2'b11, 2'b00, 2'b00, 8, 7, 0, 0);
      checkOutput("tp5Readback", bif.rdata, 32'hCAFE0001);

      pv[0] = 1'b0;
      pv[1] = 1'b0;
      pw    = 2'b00;
      pa[0] = '0;
      pa[1] = '0;
      pd[0] = '0;
      pd[1] = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pv[p] && $urandom_range(0, 9) < 7) begin
               pv[p] = 1'b1;
               pw[p] = 1'($urandom_range(0, 1));
               case ($urandom_range(0, 9))
                  0:       pa[p] = $urandom;
                  1:       pa[p] = 32'(DEPTH) + 32'($urandom_range(0, 3));
                  2, 3, 4: pa[p] = 32'($urandom_range(0, 7));
                  default: pa[p] = 32'($urandom_range(0, DEPTH - 1));
               endcase
               pd[p] = $urandom;
            end else if (pv[p] && $urandom_range(0, 19) == 0) begin
               pv[p] = 1'b0;
            end
            lk[p] = ($urandom_range(0, 9) < 6);
         end
         rr = ($urandom_range(0, 99) == 0);
         applyStimulus(rr, {pv[1], pv[0]}, lk, pw, pa[0], pa[1], pd[0], pd[1]);
         for (int p = 0; p < 2; p++) begin
            if (lastGnt[p]) pv[p] = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-cycle core's data memory between the core load/store port (port 0) and the testbench/loader port (port 1). It sits directly in front of the data memory and drives its address, write-data and write-enable pins. Requests are arbitrated round-robin with an optional lock that allows bounded bursts. Read data and an error flag come back one cycle after the grant.

## Interface
- `AW`, default 32: address width of both requester ports.
- `DW`, default 32: data width.
- `DEPTH`, default 256: number of valid word locations. Addresses `>= DEPTH` are out of range.
- `MAX_BURST`, default 4: maximum number of consecutive locked grants while the other port is waiting.
- `clk` in, 1: single clock. All state updates on `posedge clk`.
- `rst` in, 1: reset. Synchronous, active-high.
- `req[1:0]` in, 2: per-port request. Command must be held stable until granted.
- `lock[1:0]` in, 2: per-port burst-lock hint. Sampled only while the port is granted.
- `wr[1:0]` in, 2: per-port write (1) or read (0).
- `addr0`, `addr1` in, AW each: per-port word address.
- `wdata0`, `wdata1` in, DW each: per-port write data.
- `gnt[1:0]` out, 2: combinational one-hot grant for the current cycle.
- `rvalid[1:0]` out, 2: registered; pulses in the cycle after a grant to that port.
- `rdata` out, DW: registered read data, qualified by `rvalid`. Holds its last value otherwise.
- `err` out, 1: registered; qualified by `rvalid`. Set when the granted access was out of range.
- `mem_A` out, AW: memory address.
- `mem_WD` out, DW: memory write data.
- `mem_we` out, 1: memory write enable.
- `mem_RD` in, DW: combinational memory read data.

## Operation
- State machine has three states: `ARB`, `LOCK0`, `LOCK1`. Reset state is `ARB`.
- **`ARB`**
  - With a single requester, that port is granted.
  - With both requesting, the port selected by the `rr_ptr` register is granted. `rr_ptr` resets to 0.
  - After a grant, `rr_ptr` is set to the other port.
  - If the granted port has `lock` high, the next state is `LOCKk` and `burst_cnt` is set to 1.
- **`LOCKk`**
  - Only port k can be granted. The other port is held off.
  - On a grant, `burst_cnt` increments.
  - Return to `ARB` when any of these holds:
    - `req[k]` is low;
    - `lock[k]` is low at the grant;
    - `burst_cnt == MAX_BURST` with the other port requesting (forced release, `rr_ptr` set to the other port).
  - Without contention, the burst is unbounded. `burst_cnt` saturates at `MAX_BURST`.
- **Memory drive**
  - `mem_A` and `mem_WD` are muxed from the granted port; port 0 when nothing is granted.
  - `mem_we = |gnt & wr[granted] & in_range`, where `in_range = addr < DEPTH` using an unsigned compare on the full AW bits.
- **Response**
  - `rdata <= mem_RD` is captured at the grant edge, for writes as well. For an in-range write, `rdata` is the pre-write content.
  - `err <= !in_range`.
  - `rvalid[k] <= gnt[k]`.
- An out-of-range write never asserts `mem_we`. An out-of-range read returns `rdata = 0` and `err = 1`.

## Timing
- Grant is combinational in the cycle where `req` is high. The memory write commits at the end of that cycle. `rvalid`, `rdata` and `err` appear one cycle later.
- Throughput is one access per cycle. Back-to-back grants to the same port are allowed.
- Reset values: `gnt = 0`, `rvalid = 0`, `rdata = 0`, `err = 0`, `mem_we = 0`; `rr_ptr = 0`, `burst_cnt = 0`, state `ARB`.
- While `rst` is high, `gnt` and `mem_we` are forced to 0.
- Reset asserted mid-burst:
  - the lock is dropped immediately;
  - no write is committed in the reset cycle;
  - any pending `rvalid` is cleared.
- A port that drops `req` without receiving a grant loses nothing. No response is generated for it.
- Both ports writing the same address in consecutive cycles: the memory holds the later write. There is no forwarding; a read granted in the cycle after a write sees the new data.

## Structure
- Package `dmem_arb_pkg` holds:
  - `arb_state_t` enum (`ARB`, `LOCK0`, `LOCK1`);
  - port index constants `P_CORE = 0`, `P_LOAD = 1`;
  - the default `DEPTH` constant.
- Sub-module `rr_pick2` is a natural split: combinational 2-way round-robin pick from `req` and `rr_ptr`. The FSM, burst counter and response registers stay in the top.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF to address 5 and then reads address 5 → `mem_we` is high for one cycle. The read response has `rvalid[0] = 1`, `rdata = 0xDEADBEEF`, `err = 0`.
- Both ports request continuously with no lock → grants alternate 0,1,0,1 starting with port 0 after reset.
- Port 1 locked and requesting every cycle, port 0 requesting, `MAX_BURST = 4` → port 1 gets exactly 4 consecutive grants, then port 0 is granted.
- Port 0 writes address 256 and then reads address 0xFFFFFFFF → `mem_we` stays 0. Both responses have `err = 1`; the read has `rdata = 0`.
- `rst` asserted in the 2nd cycle of a locked write burst from port 1 → no `mem_we` in the reset cycle. After reset, state is `ARB`, `rr_ptr = 0`, and port 0 wins the next contention.
